// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// Entry rd_addr is sized for the widest supported register address.
package pipe_pkg;

  localparam int unsigned PIPE_RAW_MAX = 8;

  typedef struct packed {
    logic                    valid;
    logic                    rd_en;
    logic                    is_load;
    logic [PIPE_RAW_MAX-1:0] rd_addr;
  } pipe_entry_t;

  localparam pipe_entry_t PIPE_BUBBLE = '0;

  function automatic int fwd_sel_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority match of one ID source operand against tracked stages.
// Youngest matching stage wins; x0 never matches.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int NumStages   = 3,
  parameter int FwdSelW     = 2,
  parameter int LoadLatency = 1
) (
  input  pipe_entry_t [NumStages-1:0] entries_i,
  input  logic [PIPE_RAW_MAX-1:0]     rs_i,
  input  logic                        rs_used_i,
  output logic [FwdSelW-1:0]          fwd_sel_o,
  output logic                        load_hit_o
);

  logic [NumStages-1:0] hit;

  always_comb begin
    for (int k = 0; k < NumStages; k++) begin
      hit[k] = entries_i[k].valid && entries_i[k].rd_en &&
               (entries_i[k].rd_addr != '0) &&
               (entries_i[k].rd_addr == rs_i) && rs_used_i;
    end
  end

  always_comb begin
    fwd_sel_o  = '0;
    load_hit_o = 1'b0;
    for (int k = NumStages - 1; k >= 0; k--) begin
      if (hit[k]) begin
        fwd_sel_o = FwdSelW'(k + 1);
      end
      if (hit[k] && entries_i[k].is_load && (k < LoadLatency)) begin
        load_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard control: forwarding, load-use stall, redirect flush.
// Optional PIPE_PERF_CNT_EN adds saturating stall/flush counters.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter int NumStages    = 3,
  parameter int RegAddrWidth = 5,
  parameter int LoadLatency  = 1,
  parameter int CntWidth     = 32,
  localparam int FwdSelW     = fwd_sel_width(NumStages)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_ready,
  input  logic                    id_valid,
  input  logic [RegAddrWidth-1:0] id_rs1_addr,
  input  logic [RegAddrWidth-1:0] id_rs2_addr,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [RegAddrWidth-1:0] id_rd_addr,
  input  logic                    id_rd_en,
  input  logic                    id_is_load,
  input  logic                    br_redirect,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    flush_id,
  output logic [FwdSelW-1:0]      fwd_rs1_sel,
  output logic [FwdSelW-1:0]      fwd_rs2_sel,
  output logic [NumStages-1:0]    stage_valid,
  output logic                    wb_rd_en,
  output logic [RegAddrWidth-1:0] wb_rd_addr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CntWidth-1:0]     stall_cnt,
  output logic [CntWidth-1:0]     flush_cnt
`endif
);

  pipe_entry_t [NumStages-1:0] entry_q, entry_d;
  pipe_entry_t id_info;
  logic hit1, hit2;
  logic load_use, inject;

  fwd_match #(
    .NumStages  (NumStages),
    .FwdSelW    (FwdSelW),
    .LoadLatency(LoadLatency)
  ) u_fwd_rs1 (
    .entries_i (entry_q),
    .rs_i      (PIPE_RAW_MAX'(id_rs1_addr)),
    .rs_used_i (id_rs1_used),
    .fwd_sel_o (fwd_rs1_sel),
    .load_hit_o(hit1)
  );

  fwd_match #(
    .NumStages  (NumStages),
    .FwdSelW    (FwdSelW),
    .LoadLatency(LoadLatency)
  ) u_fwd_rs2 (
    .entries_i (entry_q),
    .rs_i      (PIPE_RAW_MAX'(id_rs2_addr)),
    .rs_used_i (id_rs2_used),
    .fwd_sel_o (fwd_rs2_sel),
    .load_hit_o(hit2)
  );

  assign load_use = id_valid && (hit1 || hit2);
  assign inject   = load_use || br_redirect;

  // Redirect wins over load-use; a frozen pipe stalls unconditionally.
  assign stall_if = mem_ready ? (load_use && !br_redirect) : 1'b1;
  assign stall_id = stall_if;
  assign flush_id = mem_ready && br_redirect;

  always_comb begin
    id_info         = PIPE_BUBBLE;
    id_info.valid   = id_valid;
    id_info.rd_en   = id_rd_en;
    id_info.is_load = id_is_load;
    id_info.rd_addr = PIPE_RAW_MAX'(id_rd_addr);
  end

  always_comb begin
    entry_d = entry_q;
    if (mem_ready) begin
      entry_d[0] = inject ? PIPE_BUBBLE : id_info;
      for (int k = 1; k < NumStages; k++) begin
        entry_d[k] = entry_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int k = 0; k < NumStages; k++) begin
      stage_valid[k] = entry_q[k].valid;
    end
  end

  assign wb_rd_en = entry_q[NumStages-1].valid &&
                    entry_q[NumStages-1].rd_en &&
                    (entry_q[NumStages-1].rd_addr != '0);
  assign wb_rd_addr = entry_q[NumStages-1].rd_addr[RegAddrWidth-1:0];

`ifdef PIPE_PERF_CNT_EN
  logic [CntWidth-1:0] stall_cnt_q, flush_cnt_q;
  logic stall_ev, flush_ev;

  assign stall_ev = mem_ready && load_use && !br_redirect;
  assign flush_ev = mem_ready && br_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_ev && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_cntw;
  assign unused_cntw = |CntWidth;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed vector bench for pipe_hazard_ctl.
// Table stream plus freeze and async-reset sequences.
module tb_pipe_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_ready, id_valid;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic       id_rs1_used, id_rs2_used, id_rd_en, id_is_load;
  logic       br_redirect;
  logic       stall_if, stall_id, flush_id;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [2:0] stage_valid;
  logic       wb_rd_en;
  logic [4:0] wb_rd_addr;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_ready  (mem_ready),
    .id_valid   (id_valid),
    .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd_addr (id_rd_addr),
    .id_rd_en   (id_rd_en),
    .id_is_load (id_is_load),
    .br_redirect(br_redirect),
    .stall_if   (stall_if),
    .stall_id   (stall_id),
    .flush_id   (flush_id),
    .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel),
    .stage_valid(stage_valid),
    .wb_rd_en   (wb_rd_en),
    .wb_rd_addr (wb_rd_addr)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  typedef struct packed {
    logic       mr;
    logic       iv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       en;
    logic       ld;
    logic       br;
    logic       sif;
    logic       sid;
    logic       fl;
    logic [1:0] f1;
    logic [1:0] f2;
    logic [2:0] sv;
    logic       wen;
    logic [4:0] wad;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input int id,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step%0d: got %0d want %0d", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic iv,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic en,
                       input logic ld, input logic br);
    mem_ready   = mr;
    id_valid    = iv;
    id_rs1_addr = rs1;
    id_rs2_addr = rs2;
    id_rs1_used = u1;
    id_rs2_used = u2;
    id_rd_addr  = rd;
    id_rd_en    = en;
    id_is_load  = ld;
    br_redirect = br;
  endtask

  task automatic chk_all(input int id, input vec_t v);
    chk("stall_if", id, int'(stall_if), int'(v.sif));
    chk("stall_id", id, int'(stall_id), int'(v.sid));
    chk("flush_id", id, int'(flush_id), int'(v.fl));
    chk("fwd_rs1", id, int'(fwd_rs1_sel), int'(v.f1));
    chk("fwd_rs2", id, int'(fwd_rs2_sel), int'(v.f2));
    chk("stage_valid", id, int'(stage_valid), int'(v.sv));
    chk("wb_rd_en", id, int'(wb_rd_en), int'(v.wen));
    chk("wb_rd_addr", id, int'(wb_rd_addr), int'(v.wad));
  endtask

  initial begin
    // mr iv rs1 rs2 u1 u2 rd en ld br | sif sid fl f1 f2 sv wen wad
    vecs[0]  = '{1,1, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,3'b000,0, 0};
    vecs[1]  = '{1,1, 1, 2,1,1, 5,1,0,0, 0,0,0,0,0,3'b000,0, 0};
    vecs[2]  = '{1,1, 5, 3,1,1, 6,1,0,0, 0,0,0,1,0,3'b001,0, 0};
    vecs[3]  = '{1,1, 5, 6,1,1, 0,0,0,0, 0,0,0,2,1,3'b011,0, 0};
    vecs[4]  = '{1,1, 5, 9,1,1, 0,0,0,0, 0,0,0,3,0,3'b111,1, 5};
    vecs[5]  = '{1,1, 6, 0,1,1, 7,1,1,0, 0,0,0,3,0,3'b111,1, 6};
    vecs[6]  = '{1,1, 1, 7,1,1, 8,1,0,0, 1,1,0,0,1,3'b111,0, 0};
    vecs[7]  = '{1,1, 1, 7,1,1, 8,1,0,0, 0,0,0,0,2,3'b110,0, 0};
    vecs[8]  = '{1,1, 3, 4,1,1, 0,1,0,0, 0,0,0,0,0,3'b101,1, 7};
    vecs[9]  = '{1,1, 0, 0,1,1, 0,0,0,0, 0,0,0,0,0,3'b011,0, 0};
    vecs[10] = '{1,1, 8, 8,0,1,11,1,1,0, 0,0,0,0,3,3'b111,1, 8};
    vecs[11] = '{1,1,11, 2,1,1,12,1,0,1, 0,0,1,1,0,3'b111,0, 0};
    vecs[12] = '{1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,3'b110,0, 0};
    vecs[13] = '{0,1,11, 0,1,0,13,1,0,1, 1,1,0,3,0,3'b100,1,11};
    vecs[14] = '{0,1,11, 0,1,0,13,1,0,0, 1,1,0,3,0,3'b100,1,11};
    vecs[15] = '{1,1,11, 0,1,0,13,1,0,0, 0,0,0,3,0,3'b100,1,11};
    vecs[16] = '{1,0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0,3'b001,0, 0};
    // Entry 0 of the table doubles as the idle stream start.
    vecs[0].iv = 1'b0;

    rst_n = 1'b0;
    drive(1, 1, 5, 5, 1, 1, 5, 1, 1, 0);
    #3;
    chk("rst_stall_if", 0, int'(stall_if), 0);
    chk("rst_valid", 0, int'(stage_valid), 0);
    chk("rst_fwd1", 0, int'(fwd_rs1_sel), 0);
    chk("rst_wb_en", 0, int'(wb_rd_en), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      vec_t v;
      v = vecs[i];
      if (i != 0) @(negedge clk);
      drive(v.mr, v.iv, v.rs1, v.rs2, v.u1, v.u2,
            v.rd, v.en, v.ld, v.br);
      #1;
      chk_all(i, v);
    end

`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", 99, int'(stall_cnt), 1);
    chk("flush_cnt", 99, int'(flush_cnt), 1);
`endif

    // Fill EX/MEM/WB with x22/x21/x20, then freeze four cycles.
    for (int r = 20; r < 23; r++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, 0, 0, 5'(r), 1, 0, 0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(0, 1, 21, 20, 1, 1, 9, 1, 0, 0);
      #1;
      chk("frz_stall", 100 + c, int'(stall_if), 1);
      chk("frz_valid", 100 + c, int'(stage_valid), 7);
      chk("frz_fwd1", 100 + c, int'(fwd_rs1_sel), 2);
      chk("frz_fwd2", 100 + c, int'(fwd_rs2_sel), 3);
      chk("frz_wb", 100 + c, int'(wb_rd_addr), 20);
    end
    @(negedge clk);
    drive(1, 0, 21, 20, 1, 1, 0, 0, 0, 0);
    #1;
    chk("res_stall", 110, int'(stall_if), 0);
    chk("res_fwd1", 110, int'(fwd_rs1_sel), 2);
    @(negedge clk);
    #1;
    chk("res_valid", 111, int'(stage_valid), 6);
    chk("res_fwd1", 111, int'(fwd_rs1_sel), 3);
    chk("res_fwd2", 111, int'(fwd_rs2_sel), 0);
    chk("res_wb", 111, int'(wb_rd_addr), 21);
    @(negedge clk);
    #1;
    chk("res_valid", 112, int'(stage_valid), 4);
    chk("res_fwd1", 112, int'(fwd_rs1_sel), 0);
    chk("res_wb", 112, int'(wb_rd_addr), 22);

    // Async reset while a load-use stall is active.
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 7, 1, 1, 0);
    @(negedge clk);
    drive(1, 1, 1, 7, 1, 1, 8, 1, 0, 0);
    #1;
    chk("pre_rst_stall", 120, int'(stall_if), 1);
    chk("pre_rst_fwd2", 120, int'(fwd_rs2_sel), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall_if", 121, int'(stall_if), 0);
    chk("mid_rst_stall_id", 121, int'(stall_id), 0);
    chk("mid_rst_valid", 121, int'(stage_valid), 0);
    chk("mid_rst_fwd2", 121, int'(fwd_rs2_sel), 0);
    chk("mid_rst_wb_en", 121, int'(wb_rd_en), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
